// File: rtl/exu_issue_stage_pkg.sv
// Shared processor definitions for the issue stage: data widths, the control-word
// layout carried from decode, and the execution-unit selector encodings.
package exu_issue_stage_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    EXU_ALU  = 2'd0,
    EXU_MDU  = 2'd1,
    EXU_FPU  = 2'd2,
    EXU_RSVD = 2'd3
  } exu_op_e;

  // Field order fixes the bit offsets: shift in [14:10], unit select in [9:8],
  // ALU op in [7:4], MDU op in [3], FPU op in [2:0].
  typedef struct packed {
    logic [4:0] exu_shift;
    exu_op_e    exu_op;
    logic [3:0] alu_op;
    logic       mdu_op;
    logic [2:0] fpu_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/exu_operand_fwd.sv
// Per-operand dependency match and operand select for the issue stage.
// Build option EXU_ISSUE_FWD_EN enables forwarding; otherwise only the hazard flag is meaningful.
module exu_operand_fwd
  import exu_issue_stage_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic [XLEN-1:0]       rf_data_i,
  input  logic                  held_valid_i,
  input  logic [REG_ADDR_W-1:0] held_rd_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [XLEN-1:0]       ex_result_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]       wb_data_i,
  output logic                  hazard_o,
  output logic                  late_fwd_o,
  output logic [XLEN-1:0]       operand_o
);

  logic rs_nz_s;
  logic held_hit_s;
  logic ex_hit_s;
  logic wb_hit_s;

  // Register 0 is hard-wired, so it never creates a dependency.
  assign rs_nz_s    = (rs_addr_i != {REG_ADDR_W{1'b0}});
  assign held_hit_s = rs_nz_s & held_valid_i & (held_rd_i == rs_addr_i);
  assign ex_hit_s   = rs_nz_s & (ex_rd_i == rs_addr_i);
  assign wb_hit_s   = rs_nz_s & (wb_rd_i == rs_addr_i);
  assign hazard_o   = held_hit_s | ex_hit_s | wb_hit_s;

`ifdef EXU_ISSUE_FWD_EN
  // Youngest producer wins; a held-instruction hit is resolved later from iExResult.
  always_comb begin
    late_fwd_o = 1'b0;
    operand_o  = rf_data_i;
    if (held_hit_s) begin
      late_fwd_o = 1'b1;
      operand_o  = rf_data_i;
    end else if (ex_hit_s) begin
      operand_o  = ex_result_i;
    end else if (wb_hit_s) begin
      operand_o  = wb_data_i;
    end else begin
      operand_o  = rf_data_i;
    end
  end
`else
  logic unused_fwd_data_s;
  assign unused_fwd_data_s = ^{ex_result_i, wb_data_i};
  assign late_fwd_o        = 1'b0;
  assign operand_o         = rf_data_i;
`endif

endmodule

// File: rtl/exu_issue_stage.sv
// Issue stage: holds one decoded instruction for the execution unit and resolves its operands.
// Build option EXU_ISSUE_FWD_EN selects operand forwarding; without it dependencies stall issue.
module exu_issue_stage
  import exu_issue_stage_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [REG_ADDR_W-1:0]  iRs0Addr,
  input  logic [REG_ADDR_W-1:0]  iRs1Addr,
  input  logic [XLEN-1:0]        iRs0Data,
  input  logic [XLEN-1:0]        iRs1Data,
  input  logic [REG_ADDR_W-1:0]  iRdAddr,
  input  logic [CTRL_W-1:0]      iCtrl,
  input  logic                   iFlush,
  input  logic                   iExBusy,
  input  logic [REG_ADDR_W-1:0]  iExRdAddr,
  input  logic [XLEN-1:0]        iExResult,
  input  logic [REG_ADDR_W-1:0]  iWbRdAddr,
  input  logic [XLEN-1:0]        iWbData,
  output logic                   oValid,
  output logic [XLEN-1:0]        oSrc0,
  output logic [XLEN-1:0]        oSrc1,
  output logic [CTRL_W-1:0]      oCtrl,
  output logic [REG_ADDR_W-1:0]  oRdAddr,
  output logic [STALL_CNT_W-1:0] oStallCnt
);

  logic                   valid_q, valid_d;
  logic                   late0_q, late0_d;
  logic                   late1_q, late1_d;
  logic [XLEN-1:0]        src0_q, src0_d;
  logic [XLEN-1:0]        src1_q, src1_d;
  ctrl_t                  ctrl_q, ctrl_d;
  logic [REG_ADDR_W-1:0]  rd_q, rd_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic                   hz0_s, hz1_s, hazard_s, capture_s;
  logic                   late0_s, late1_s;
  logic [XLEN-1:0]        op0_s, op1_s;

  exu_operand_fwd u_fwd_rs0 (
    .rs_addr_i    (iRs0Addr),
    .rf_data_i    (iRs0Data),
    .held_valid_i (valid_q),
    .held_rd_i    (rd_q),
    .ex_rd_i      (iExRdAddr),
    .ex_result_i  (iExResult),
    .wb_rd_i      (iWbRdAddr),
    .wb_data_i    (iWbData),
    .hazard_o     (hz0_s),
    .late_fwd_o   (late0_s),
    .operand_o    (op0_s)
  );

  exu_operand_fwd u_fwd_rs1 (
    .rs_addr_i    (iRs1Addr),
    .rf_data_i    (iRs1Data),
    .held_valid_i (valid_q),
    .held_rd_i    (rd_q),
    .ex_rd_i      (iExRdAddr),
    .ex_result_i  (iExResult),
    .wb_rd_i      (iWbRdAddr),
    .wb_data_i    (iWbData),
    .hazard_o     (hz1_s),
    .late_fwd_o   (late1_s),
    .operand_o    (op1_s)
  );

`ifdef EXU_ISSUE_FWD_EN
  logic unused_hazard_s;
  assign unused_hazard_s = hz0_s | hz1_s;
  assign hazard_s        = 1'b0;
`else
  assign hazard_s        = hz0_s | hz1_s;
`endif

  assign oReady    = ~iExBusy & ~hazard_s;
  assign capture_s = iValid & oReady & ~iFlush;

  // Pipeline register next state: flush beats busy-hold, which beats capture.
  always_comb begin
    valid_d = valid_q;
    late0_d = late0_q;
    late1_d = late1_q;
    src0_d  = src0_q;
    src1_d  = src1_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    if (iFlush) begin
      valid_d = 1'b0;
      late0_d = 1'b0;
      late1_d = 1'b0;
    end else if (iExBusy) begin
      valid_d = valid_q;
    end else if (capture_s) begin
      valid_d = 1'b1;
      late0_d = late0_s;
      late1_d = late1_s;
      src0_d  = op0_s;
      src1_d  = op1_s;
      ctrl_d  = ctrl_t'(iCtrl);
      rd_d    = iRdAddr;
    end else begin
      valid_d = 1'b0;
      late0_d = 1'b0;
      late1_d = 1'b0;
    end
  end

  // Saturating count of cycles an offered instruction was refused.
  always_comb begin
    stall_d = stall_q;
    if (iValid && !oReady && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      valid_q <= 1'b0;
      late0_q <= 1'b0;
      late1_q <= 1'b0;
      src0_q  <= {XLEN{1'b0}};
      src1_q  <= {XLEN{1'b0}};
      ctrl_q  <= ctrl_t'({CTRL_W{1'b0}});
      rd_q    <= {REG_ADDR_W{1'b0}};
      stall_q <= {STALL_CNT_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      late0_q <= late0_d;
      late1_q <= late1_d;
      src0_q  <= src0_d;
      src1_q  <= src1_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      stall_q <= stall_d;
    end
  end

  // A late-forwarded operand tracks the producer's result while it sits in EX.
  assign oValid    = valid_q;
  assign oSrc0     = late0_q ? iExResult : src0_q;
  assign oSrc1     = late1_q ? iExResult : src1_q;
  assign oCtrl     = ctrl_q;
  assign oRdAddr   = rd_q;
  assign oStallCnt = stall_q;

endmodule

// File: tb/tb_exu_issue_stage.sv
// Randomized scoreboard bench for exu_issue_stage; follows EXU_ISSUE_FWD_EN like the design.
module tb_exu_issue_stage;

  localparam int     STALL_CNT_W = 16;
  localparam longint STALL_MAX   = (64'd1 << STALL_CNT_W) - 64'd1;
`ifdef EXU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int DEP_STALLS = FWD ? 0 : 3;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iValid, iFlush, iExBusy;
  logic [4:0]  iRs0Addr, iRs1Addr, iRdAddr, iExRdAddr, iWbRdAddr;
  logic [31:0] iRs0Data, iRs1Data, iExResult, iWbData;
  logic [14:0] iCtrl;
  logic        oReady, oValid;
  logic [31:0] oSrc0, oSrc1;
  logic [14:0] oCtrl;
  logic [4:0]  oRdAddr;
  logic [15:0] oStallCnt;

  always #5 iClk = ~iClk;

  exu_issue_stage #(.STALL_CNT_W(STALL_CNT_W)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .oReady(oReady),
    .iRs0Addr(iRs0Addr), .iRs1Addr(iRs1Addr), .iRs0Data(iRs0Data), .iRs1Data(iRs1Data),
    .iRdAddr(iRdAddr), .iCtrl(iCtrl), .iFlush(iFlush), .iExBusy(iExBusy),
    .iExRdAddr(iExRdAddr), .iExResult(iExResult), .iWbRdAddr(iWbRdAddr), .iWbData(iWbData),
    .oValid(oValid), .oSrc0(oSrc0), .oSrc1(oSrc1), .oCtrl(oCtrl), .oRdAddr(oRdAddr),
    .oStallCnt(oStallCnt)
  );

  // Expected issued instruction; a late operand must equal iExResult while presented.
  typedef struct {
    logic [31:0] s0;
    logic [31:0] s1;
    bit          l0;
    bit          l1;
    logic [14:0] ctrl;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;

  // Reference model state: what the stage holds and how many refusals occurred.
  bit          m_valid;
  logic [4:0]  m_rd;
  longint      m_stalls;
  bit          exp_valid, exp_ready;
  logic [15:0] exp_stall;
  logic [15:0] cnt_before;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit depends(input logic [4:0] rs);
    return (rs != 5'd0) && ((m_valid && m_rd == rs) || iExRdAddr == rs || iWbRdAddr == rs);
  endfunction

  task automatic resolve(input logic [4:0] rs, input logic [31:0] rf,
                         output bit late, output logic [31:0] val);
    late = 1'b0;
    val  = rf;
`ifdef EXU_ISSUE_FWD_EN
    if (rs != 5'd0) begin
      if (m_valid && m_rd == rs) late = 1'b1;
      else if (iExRdAddr == rs)  val = iExResult;
      else if (iWbRdAddr == rs)  val = iWbData;
    end
`endif
  endtask

  // Evaluate the current cycle's inputs against the rules, then advance the model.
  task automatic model_step();
    exp_t e;
    bit   hz;
    exp_valid = m_valid;
    exp_stall = 16'((m_stalls > STALL_MAX) ? STALL_MAX : m_stalls);
    hz        = FWD ? 1'b0 : (depends(iRs0Addr) || depends(iRs1Addr));
    exp_ready = !iExBusy && !hz;
    if (iValid && !exp_ready) m_stalls++;
    if (iFlush) begin
      m_valid = 1'b0;
    end else if (iExBusy) begin
      m_valid = m_valid;
    end else if (iValid && exp_ready) begin
      resolve(iRs0Addr, iRs0Data, e.l0, e.s0);
      resolve(iRs1Addr, iRs1Data, e.l1, e.s1);
      e.ctrl = iCtrl;
      e.rd   = iRdAddr;
      sb.push_back(e);
      m_valid = 1'b1;
      m_rd    = iRdAddr;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_rd     = 5'd0;
    m_stalls = 0;
    sb.delete();
  endtask

  task automatic step();
    model_step();
    @(posedge iClk);
    #1;
  endtask

  task automatic idle();
    iValid = 1'b0; iFlush = 1'b0; iExBusy = 1'b0;
    iRs0Addr = 5'd0; iRs1Addr = 5'd0; iRdAddr = 5'd0; iExRdAddr = 5'd0; iWbRdAddr = 5'd0;
    iRs0Data = 32'd0; iRs1Data = 32'd0; iExResult = 32'd0; iWbData = 32'd0; iCtrl = 15'd0;
  endtask

  task automatic rand_inputs();
    iValid    = ($urandom_range(9, 0) < 7);
    iExBusy   = ($urandom_range(3, 0) == 0);
    iFlush    = ($urandom_range(19, 0) == 0);
    iRs0Addr  = 5'($urandom_range(7, 0));
    iRs1Addr  = 5'($urandom_range(7, 0));
    iRdAddr   = 5'($urandom_range(7, 0));
    iExRdAddr = 5'($urandom_range(7, 0));
    iWbRdAddr = 5'($urandom_range(7, 0));
    iRs0Data  = $urandom;
    iRs1Data  = $urandom;
    iWbData   = $urandom;
    iCtrl     = 15'($urandom);
    if (!iExBusy) iExResult = $urandom;
  endtask

  // Monitor: per-cycle handshake and counter checks; pops an entry as each instruction leaves.
  always @(negedge iClk) begin
    if (chk_en) begin
      chk("ready", 32'(oReady), 32'(exp_ready));
      chk("valid", 32'(oValid), 32'(exp_valid));
      chk("stall_cnt", 32'(oStallCnt), 32'(exp_stall));
      if (oValid && (!iExBusy || iFlush)) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL issue: unexpected instruction rd=%0d, expected none", oRdAddr);
        end else begin
          mon_e = sb.pop_front();
          chk("src0", oSrc0, mon_e.l0 ? iExResult : mon_e.s0);
          chk("src1", oSrc1, mon_e.l1 ? iExResult : mon_e.s1);
          chk("ctrl", 32'(oCtrl), 32'(mon_e.ctrl));
          chk("rd", 32'(oRdAddr), 32'(mon_e.rd));
        end
      end
    end
  end

  initial begin
    idle();
    model_reset();
    iRst_n = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_src0", oSrc0, 32'd0);
    chk("rst_src1", oSrc1, 32'd0);
    chk("rst_ctrl", 32'(oCtrl), 32'd0);
    chk("rst_rd", 32'(oRdAddr), 32'd0);
    chk("rst_stall", 32'(oStallCnt), 32'd0);
    iRst_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      step();
    end

    // r0 never matches, even against an EX result for register 0
    idle(); step();
    iValid = 1'b1; iRs0Data = 32'h5A5A; iExResult = 32'hFFFF; iRdAddr = 5'd1;
    step();
    chk("r0_src0", oSrc0, 32'h5A5A);

    // write-back forward on rs1
    idle();
    iValid = 1'b1; iRs1Addr = 5'd5; iWbRdAddr = 5'd5; iWbData = 32'hCAFE; iRdAddr = 5'd2;
    step();
    chk("wb_valid", 32'(oValid), 32'(FWD));
`ifdef EXU_ISSUE_FWD_EN
    chk("wb_src1", oSrc1, 32'hCAFE);
`endif

    // back-to-back dependency on the held producer
    idle(); step();
    iValid = 1'b1; iRdAddr = 5'd3;
    step();
    iRs0Addr = 5'd3; iRdAddr = 5'd4;
    #1;
    chk("b2b_ready", 32'(oReady), 32'(FWD));
    step();
    idle();
    iExResult = 32'h1234;
    #1;
    chk("b2b_valid", 32'(oValid), 32'(FWD));
`ifdef EXU_ISSUE_FWD_EN
    chk("b2b_src0", oSrc0, 32'h1234);
`endif
    step();

    // rd 7 dependency carried through held, EX and WB
    iValid = 1'b1; iRdAddr = 5'd7;
    step();
    cnt_before = oStallCnt;
    iRs0Addr = 5'd7; iRdAddr = 5'd8;
    step();
    iExRdAddr = 5'd7;
    step();
    iExRdAddr = 5'd0; iWbRdAddr = 5'd7;
    step();
    iWbRdAddr = 5'd0;
    step();
    chk("dep_stall_delta", 32'(16'(oStallCnt - cnt_before)), DEP_STALLS);
    chk("dep_issued", 32'(oValid), 32'd1);

    // flush while busy drops the held instruction
    iRs0Addr = 5'd0; iExBusy = 1'b1; iFlush = 1'b1;
    step();
    chk("flush_busy_valid", 32'(oValid), 32'd0);

    // long busy stall saturates the counter, then reset lands mid-stall
    idle();
    iValid = 1'b1; iRdAddr = 5'd9;
    step();
    iExBusy = 1'b1;
    for (int i = 0; i < 65541; i++) step();
    chk("stall_sat", 32'(oStallCnt), 32'h0000FFFF);
    chk_en = 1'b0;
    iRst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(oValid), 32'd0);
    chk("midrst_src0", oSrc0, 32'd0);
    chk("midrst_rd", 32'(oRdAddr), 32'd0);
    chk("midrst_stall", 32'(oStallCnt), 32'd0);
    model_reset();
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    idle();
    chk_en = 1'b1;
    step();

    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      step();
    end
    idle();
    step();
    step();
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
